// File: rtl/seq_detect_pkg.sv
// Shared limits and elaboration-time helpers for the parametrised sequence detector.
// The delta (KMP transition) function here is only ever evaluated on constants.
package seq_detect_pkg;

    localparam int unsigned PAT_W_MAX = 16;
    localparam int unsigned CNT_W_MAX = 32;

    function automatic int unsigned state_width(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Bit strings are held as integers with the most recently received bit in the LSB.
    function automatic int unsigned next_state(input int unsigned pattern,
                                               input int unsigned pat_w,
                                               input int unsigned k,
                                               input logic        b);
        int unsigned text;
        int unsigned len_top;
        int unsigned res;
        text    = ((pattern >> (pat_w - k)) << 1) | 32'(b);
        len_top = (k + 1 < pat_w) ? k + 1 : pat_w;
        res     = 0;
        for (int len = 1; len <= int'(PAT_W_MAX); len++) begin
            if (unsigned'(len) <= len_top &&
                (text & ((32'd1 << len) - 32'd1)) == (pattern >> (pat_w - unsigned'(len)))) begin
                res = unsigned'(len);
            end
        end
        return res;
    endfunction

    function automatic int unsigned border_len(input int unsigned pattern,
                                               input int unsigned pat_w);
        int unsigned res;
        res = 0;
        for (int len = 1; len <= int'(PAT_W_MAX); len++) begin
            if (unsigned'(len) < pat_w &&
                (pattern & ((32'd1 << len) - 32'd1)) == (pattern >> (pat_w - unsigned'(len)))) begin
                res = unsigned'(len);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_detect_sat_cnt.sv
// Saturating up-counter for detector match events; holds at all-ones instead of wrapping.
module seq_detect_sat_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised Moore serial pattern detector with KMP fallback and runtime overlap mode.
// Build option SEQ_DETECT_CNT_EN adds a saturating match counter; otherwise match_count is 0.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int unsigned          PAT_W   = 4,
    parameter logic [PAT_W-1:0]     PATTERN = 4'b1011,
    parameter int unsigned          CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inbits,
    input  logic             in_valid,
    input  logic             overlap,
    output logic             detect,
    output logic [CNT_W-1:0] match_count
);

    localparam int unsigned SW      = state_width(PAT_W);
    localparam int unsigned NROW    = 1 << SW;
    localparam int unsigned PAT_INT = 32'(PATTERN);
    localparam int unsigned BORDER  = border_len(PAT_INT, PAT_W);

    localparam logic [SW-1:0] S_0     = '0;
    localparam logic [SW-1:0] S_MATCH = SW'(PAT_W);

    if (PAT_W < 2 || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
        $error("seq_detect_param: PAT_W out of range 2..16");
    end
    if (CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
        $error("seq_detect_param: CNT_W out of range 1..32");
    end

    // Row PAT_W is the overlapping exit from MATCH (resume at the border);
    // the non-overlapping exit reuses row 0. Unreachable encodings fall to S_0.
    logic [SW-1:0] tbl [NROW][2];

    for (genvar k = 0; k < int'(NROW); k++) begin : g_row
        for (genvar b = 0; b < 2; b++) begin : g_bit
            if (k <= int'(PAT_W)) begin : g_live
                localparam int unsigned KEFF = (k == int'(PAT_W)) ? BORDER : k;
                localparam logic [SW-1:0] NEXT = SW'(next_state(PAT_INT, PAT_W, KEFF, b == 1));
                assign tbl[k][b] = NEXT;
            end else begin : g_dead
                assign tbl[k][b] = S_0;
            end
        end
    end

    logic [SW-1:0] state_q, state_d;
    logic [SW-1:0] row;
    logic          inc;

    always_comb begin
        row     = state_q;
        state_d = state_q;
        inc     = 1'b0;
        if (state_q == S_MATCH && !overlap) begin
            row = S_0;
        end
        if (in_valid) begin
            state_d = tbl[row][inbits];
            inc     = (state_d == S_MATCH);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_0;
        end else begin
            state_q <= state_d;
        end
    end

    assign detect = (state_q == S_MATCH);

`ifdef SEQ_DETECT_CNT_EN
    seq_detect_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_sat_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc),
        .count (match_count)
    );
`else
    logic unused_inc;
    assign unused_inc  = inc;
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: three instances (1011/CNT_W=8, 1011/CNT_W=2, 1111).
// Expected counts follow the SEQ_DETECT_CNT_EN build option.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       reset, inbits, in_valid, overlap;
    logic       det_a, det_b, det_c;
    logic [7:0] cnt_a, cnt_c;
    logic [1:0] cnt_b;
    int         total  = 0;
    int         passed = 0;

`ifdef SEQ_DETECT_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut_a (
        .clk (clk), .reset (reset), .inbits (inbits), .in_valid (in_valid),
        .overlap (overlap), .detect (det_a), .match_count (cnt_a)
    );
    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) dut_b (
        .clk (clk), .reset (reset), .inbits (inbits), .in_valid (in_valid),
        .overlap (overlap), .detect (det_b), .match_count (cnt_b)
    );
    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1111), .CNT_W(8)) dut_c (
        .clk (clk), .reset (reset), .inbits (inbits), .in_valid (in_valid),
        .overlap (overlap), .detect (det_c), .match_count (cnt_c)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] cexp(input int n);
        return CntEn ? 32'(n) : 32'd0;
    endfunction

    task automatic step(input logic b, input logic v);
        @(negedge clk);
        inbits   = b;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    // Reset asserted with a valid 1 on the input: reset must win.
    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        inbits   = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    // bits/exp are MSB-first: bit n-1 is sent first.
    task automatic run(input string tag, input int n, input logic [15:0] bits,
                       input logic [15:0] exp, input int which);
        logic obs;
        for (int i = n - 1; i >= 0; i--) begin
            step(bits[i], 1'b1);
            case (which)
                0:       obs = det_a;
                1:       obs = det_b;
                default: obs = det_c;
            endcase
            check($sformatf("%s_det[%0d]", tag, n - 1 - i), 32'(obs), 32'(exp[i]));
        end
    endtask

    initial begin
        reset    = 1'b1;
        inbits   = 1'b0;
        in_valid = 1'b0;
        overlap  = 1'b1;
        @(posedge clk);
        #1;
        check("rst_det_a", 32'(det_a), 32'd0);
        check("rst_det_b", 32'(det_b), 32'd0);
        check("rst_det_c", 32'(det_c), 32'd0);
        check("rst_cnt_a", 32'(cnt_a), 32'd0);
        check("rst_cnt_b", 32'(cnt_b), 32'd0);
        check("rst_cnt_c", 32'(cnt_c), 32'd0);
        reset = 1'b0;

        // Overlapping: 1011011 matches after bits 4 and 7.
        do_reset();
        overlap = 1'b1;
        run("t1", 7, 16'b1011011, 16'b0001001, 0);
        check("t1_cnt", 32'(cnt_a), cexp(2));

        // Non-overlapping: second match lost, ends in S_1.
        do_reset();
        overlap = 1'b0;
        run("t2", 7, 16'b1011011, 16'b0001000, 0);
        check("t2_cnt", 32'(cnt_a), cexp(1));

        // KMP fallback S_3 -> S_2 on the fourth bit.
        do_reset();
        overlap = 1'b0;
        run("t3", 6, 16'b101011, 16'b000001, 0);
        check("t3_cnt", 32'(cnt_a), cexp(1));

        // Gaps in in_valid hold state and detect.
        do_reset();
        run("t4a", 2, 16'b10, 16'b00, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            check($sformatf("t4_gap_det[%0d]", i), 32'(det_a), 32'd0);
        end
        run("t4b", 2, 16'b11, 16'b01, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            check($sformatf("t4_hold_det[%0d]", i), 32'(det_a), 32'd1);
        end
        check("t4_cnt", 32'(cnt_a), cexp(1));

        // Reset mid-pattern discards progress; following 1 leaves S_1, proven by 011 matching.
        do_reset();
        run("t5a", 3, 16'b101, 16'b000, 0);
        do_reset();
        check("t5_rst_det", 32'(det_a), 32'd0);
        check("t5_rst_cnt", 32'(cnt_a), 32'd0);
        run("t5b", 1, 16'b1, 16'b0, 0);
        check("t5b_cnt", 32'(cnt_a), 32'd0);
        run("t5c", 3, 16'b011, 16'b001, 0);

        // CNT_W = 2 saturation across four overlapping matches.
        do_reset();
        overlap = 1'b1;
        run("t6a", 4, 16'b1011, 16'b0001, 1);
        check("t6_cnt1", 32'(cnt_b), cexp(1));
        run("t6b", 3, 16'b011, 16'b001, 1);
        check("t6_cnt2", 32'(cnt_b), cexp(2));
        run("t6c", 3, 16'b011, 16'b001, 1);
        check("t6_cnt3", 32'(cnt_b), cexp(3));
        run("t6d", 3, 16'b011, 16'b001, 1);
        check("t6_cnt_sat", 32'(cnt_b), cexp(3));

        // 1111 overlapping: MATCH -> MATCH keeps detect high and still counts.
        do_reset();
        overlap = 1'b1;
        run("t7", 6, 16'b111111, 16'b000111, 2);
        check("t7_cnt", 32'(cnt_c), cexp(3));

        // 1111 non-overlapping: exit from MATCH restarts at S_0.
        do_reset();
        overlap = 1'b0;
        run("t8", 6, 16'b111111, 16'b000100, 2);
        check("t8_cnt", 32'(cnt_c), cexp(1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
